// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard/mouse event path.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

    typedef struct packed {
        logic       src;
        logic       err;
        logic [7:0] data;
    } ps2_evt_t;

    localparam logic SRC_KBD   = 1'b0;
    localparam logic SRC_MOUSE = 1'b1;
endpackage

// File: rtl/ps2_rx_chan.sv
// One PS/2 receive channel: input synchronizer, falling-edge detect,
// frame FSM with inactivity timeout, and a single-entry holding register.
module ps2_rx_chan
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       hold_pop,
    output logic       hold_valid,
    output logic       hold_err,
    output logic [7:0] hold_byte,
    output logic       drop
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   fall_q, fall_d;
    logic                   bit_q, bit_d;
    ps2_state_t             state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [8:0]             hold_q, hold_d;
    logic                   frame_done, frame_err, load;

    // Edge pulse and sampled bit are registered together so data and clock stay aligned.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        fall_d      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        bit_d       = data_sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        tmo_d      = tmo_q;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall_q && !bit_q) begin
                    state_d = DATA;
                    cnt_d   = 3'd0;
                end
            end
            DATA: if (fall_q) begin
                shift_d = {bit_q, shift_q[7:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: if (fall_q) begin
                perr_d  = ~(^shift_q ^ bit_q);
                state_d = STOP;
            end
            STOP: if (fall_q) begin
                frame_done = 1'b1;
                frame_err  = perr_q | ~bit_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            if (fall_q) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // A slot being granted out this cycle may be refilled in the same cycle.
    always_comb begin
        drop         = frame_done & hold_valid_q & ~hold_pop;
        load         = frame_done & ~drop;
        hold_valid_d = load | (hold_valid_q & ~hold_pop);
        hold_d       = load ? {frame_err, shift_q} : hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            fall_q       <= 1'b0;
            bit_q        <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            tmo_q        <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            fall_q       <= fall_d;
            bit_q        <= bit_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            tmo_q        <= tmo_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

    assign hold_valid = hold_valid_q;
    assign hold_err   = hold_q[8];
    assign hold_byte  = hold_q[7:0];
endmodule

// File: rtl/ps2_event_arbiter.sv
// Keyboard + mouse PS/2 receivers, round-robin merged into one event FIFO
// presented to the core with a valid/ready handshake.
module ps2_event_arbiter
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    input  logic       mouse_clk,
    input  logic       mouse_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_src,
    output logic       evt_err,
    output logic [7:0] evt_byte,
    output logic [1:0] ovf,
    input  logic       ovf_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]      ps2_clk_in, ps2_data_in;
    logic [1:0]      hold_valid, hold_err, drop, grant;
    logic [1:0][7:0] hold_byte;

    assign ps2_clk_in  = {mouse_clk, kbd_clk};
    assign ps2_data_in = {mouse_data, kbd_data};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        ps2_rx_chan #(
            .SYNC_STAGES   (SYNC_STAGES),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .ps2_clk   (ps2_clk_in[g]),
            .ps2_data  (ps2_data_in[g]),
            .hold_pop  (grant[g]),
            .hold_valid(hold_valid[g]),
            .hold_err  (hold_err[g]),
            .hold_byte (hold_byte[g]),
            .drop      (drop[g])
        );
    end

    ps2_evt_t      mem_q [FIFO_DEPTH];
    ps2_evt_t      mem_d [FIFO_DEPTH];
    ps2_evt_t      push_evt, head;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          rr_q, rr_d;
    logic [1:0]    ovf_q, ovf_d;
    logic          empty, full, pop, push, can_push, sel;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = ~empty & evt_ready;
        can_push = ~full | pop;
        grant    = 2'b00;
        rr_d     = rr_q;
        // rr_q names the channel that wins when both holding regs are full.
        if (can_push) begin
            if (hold_valid == 2'b11) grant[rr_q] = 1'b1;
            else                     grant = hold_valid;
        end
        push = |grant;
        if (push) rr_d = grant[SRC_KBD] ? SRC_MOUSE : SRC_KBD;
        sel           = grant[SRC_MOUSE];
        push_evt.src  = sel;
        push_evt.err  = hold_err[sel];
        push_evt.data = hold_byte[sel];

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = push_evt;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        ovf_d = (ovf_clr ? 2'b00 : ovf_q) | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rr_q     <= SRC_KBD;
            ovf_q    <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign evt_valid = ~empty;
    assign evt_src   = evt_valid & head.src;
    assign evt_err   = evt_valid & head.err;
    assign evt_byte  = evt_valid ? head.data : 8'h00;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_ps2_event_arbiter.sv
// Scoreboard bench for ps2_event_arbiter: frames are driven on the PS/2 pins,
// expected events queued at send time and compared as the core side accepts them.
module tb_ps2_event_arbiter;
    localparam int SYNC = 2;
    localparam int TMO  = 8192;
    localparam int H    = 4;

    logic       clk = 1'b0;
    logic       rst, kbd_clk, kbd_data, mouse_clk, mouse_data, evt_ready, ovf_clr;
    logic       evt_valid, evt_src, evt_err;
    logic [7:0] evt_byte;
    logic [1:0] ovf;

    int         n_chk = 0, n_err = 0, cyc = 0, vld_cyc = 0;
    int         stop_cyc [2];
    logic       vld_prev = 1'b0;
    logic [9:0] sb [$];

    ps2_event_arbiter #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .kbd_clk(kbd_clk), .kbd_data(kbd_data),
        .mouse_clk(mouse_clk), .mouse_data(mouse_data), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_src(evt_src), .evt_err(evt_err),
        .evt_byte(evt_byte), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid && !vld_prev) vld_cyc = cyc;
            if (evt_valid && evt_ready) begin
                if (sb.size() == 0) chk("unexpected_evt", {22'd0, evt_src, evt_err, evt_byte}, 32'hffff_ffff);
                else                chk("evt", {22'd0, evt_src, evt_err, evt_byte}, {22'd0, sb.pop_front()});
            end
        end
        vld_prev = evt_valid;
    end

    task automatic set_clk(input bit ch, input logic v);
        if (ch) mouse_clk = v; else kbd_clk = v;
    endtask

    task automatic set_data(input bit ch, input logic v);
        if (ch) mouse_data = v; else kbd_data = v;
    endtask

    task automatic send_frame(input bit ch, input logic [7:0] b, input logic par,
                              input logic stp, input int nbits);
        logic [10:0] bits;
        bits = {stp, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            set_data(ch, bits[i]);
            repeat (H) @(posedge clk);
            #1;
            set_clk(ch, 1'b0);
            if (i == 10) stop_cyc[ch] = cyc;
            repeat (H) @(posedge clk);
            #1;
            set_clk(ch, 1'b1);
        end
        set_data(ch, 1'b1);
    endtask

    // Good frame with odd parity, expectation queued.
    task automatic send_ok(input bit ch, input logic [7:0] b, input bit expect_it);
        if (expect_it) sb.push_back({ch, 1'b0, b});
        send_frame(ch, b, ~^b, 1'b1, 11);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; kbd_clk = 1'b1; kbd_data = 1'b1; mouse_clk = 1'b1; mouse_data = 1'b1;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_src", evt_src, 0);
        chk("rst_err", evt_err, 0);
        chk("rst_byte", evt_byte, 0);
        chk("rst_ovf", ovf, 0);
        step(1);

        // 1: keyboard 0x1C, plus pin-to-valid latency
        evt_ready = 1'b1;
        send_ok(1'b0, 8'h1C, 1'b1);
        wait_drain("t1");
        chk("t1_latency", vld_cyc - stop_cyc[0], SYNC + 3);

        // 2: mouse bad parity, then bad stop bit
        sb.push_back({1'b1, 1'b1, 8'h08});
        send_frame(1'b1, 8'h08, 1'b1, 1'b1, 11);
        wait_drain("t2a");
        sb.push_back({1'b1, 1'b1, 8'hFA});
        send_frame(1'b1, 8'hFA, ~^8'hFA, 1'b0, 11);
        wait_drain("t2b");

        // 3: simultaneous completion; kbd wins after a mouse grant, mouse wins after a kbd grant
        sb.push_back({1'b0, 1'b0, 8'hA1});
        sb.push_back({1'b1, 1'b0, 8'hB1});
        fork
            send_ok(1'b0, 8'hA1, 1'b0);
            send_ok(1'b1, 8'hB1, 1'b0);
        join
        wait_drain("t3a");
        send_ok(1'b0, 8'h3C, 1'b1);
        wait_drain("t3b");
        sb.push_back({1'b1, 1'b0, 8'hB2});
        sb.push_back({1'b0, 1'b0, 8'hA2});
        fork
            send_ok(1'b0, 8'hA2, 1'b0);
            send_ok(1'b1, 8'hB2, 1'b0);
        join
        wait_drain("t3c");

        // 4: FIFO full, both holding regs full, then one drop per channel
        evt_ready = 1'b0;
        send_ok(1'b0, 8'h11, 1'b1);
        send_ok(1'b0, 8'h22, 1'b1);
        send_ok(1'b0, 8'h33, 1'b1);
        send_ok(1'b1, 8'h44, 1'b1);
        send_ok(1'b0, 8'h55, 1'b1);
        send_ok(1'b1, 8'h66, 1'b1);
        step(10);
        @(negedge clk);
        chk("t4_ovf_none", ovf, 2'b00);
        chk("t4_head", evt_byte, 8'h11);
        step(1);
        send_ok(1'b0, 8'h77, 1'b0);
        send_ok(1'b1, 8'h88, 1'b0);
        step(10);
        @(negedge clk);
        chk("t4_ovf_set", ovf, 2'b11);
        step(1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("t4_ovf_clr", ovf, 2'b00);
        step(1);
        evt_ready = 1'b1;
        wait_drain("t4");

        // 5: partial frame abandoned by timeout, next frame intact
        send_frame(1'b0, 8'h00, 1'b0, 1'b1, 6);
        step(TMO + 20);
        @(negedge clk);
        chk("t5_no_evt", evt_valid, 0);
        step(1);
        send_ok(1'b0, 8'h55, 1'b1);
        wait_drain("t5");

        // 6: reset with three queued events and a frame in progress
        evt_ready = 1'b0;
        send_ok(1'b0, 8'h01, 1'b0);
        send_ok(1'b0, 8'h02, 1'b0);
        send_ok(1'b0, 8'h03, 1'b0);
        send_frame(1'b0, 8'h0F, 1'b0, 1'b1, 4);
        step(10);
        @(negedge clk);
        chk("t6_pre_valid", evt_valid, 1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", evt_valid, 0);
        chk("t6_byte", evt_byte, 0);
        chk("t6_src_err", {evt_src, evt_err}, 2'b00);
        chk("t6_ovf", ovf, 0);
        step(4);
        @(negedge clk);
        chk("t6_still_empty", evt_valid, 0);
        step(1);
        evt_ready = 1'b1;
        send_ok(1'b0, 8'hAA, 1'b1);
        wait_drain("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
